// File: rtl/count_tick_sched.sv
// count_tick_sched: in-domain tick scheduler for the LED demo counter.
// Issues count enables over the counter's EN/RDY handshake with run, pause, step and clear control.
module count_tick_sched #(
    parameter int PRESCALE_W   = 23,
    parameter int COUNT_W      = 4,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] period,
    output logic                  ctr_en,
    input  logic                  ctr_rdy,
    output logic                  ctr_rst_n,
    input  logic [COUNT_W-1:0]    ctr_value,
    output logic [COUNT_W-1:0]    count_q,
    output logic                  wrap,
    output logic                  overrun,
    output logic [1:0]            state
);

    localparam int               CLR_W      = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_RELOAD = CLR_W'(CLEAR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e                state_q,    state_d;
    logic [CLR_W-1:0]      clr_cnt_q,  clr_cnt_d;
    logic [PRESCALE_W-1:0] presc_q,    presc_d;
    logic                  pending_q,  pending_d;
    logic                  fire_dly_q, fire_dly_d;
    logic [COUNT_W-1:0]    value_q,    value_d;
    logic                  wrap_q,     wrap_d;
    logic                  overrun_q,  overrun_d;
    logic                  rst_n_q,    rst_n_d;

    logic tick;
    logic fire;
    logic step_acc;

    // Handshake: ctr_en (valid) is the registered pending flag and stays high
    // until the counter answers with ctr_rdy in the same cycle; that cycle is
    // the transfer (fire). ctr_en never drops without a fire, except on clear or reset.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        presc_d    = presc_q;
        value_d    = value_q;
        wrap_d     = 1'b0;
        overrun_d  = overrun_q;
        pending_d  = pending_q;
        tick       = 1'b0;
        step_acc   = 1'b0;
        fire       = pending_q & ctr_rdy;
        fire_dly_d = fire;

        // The counter shows its new value one cycle after the fire.
        if (fire_dly_q) begin
            value_d = ctr_value;
            wrap_d  = (value_q == '1) && (ctr_value == '0);
        end

        if (clear) begin
            state_d    = ST_CLEAR;
            clr_cnt_d  = CLR_RELOAD;
            presc_d    = '0;
            value_d    = '0;
            wrap_d     = 1'b0;
            overrun_d  = 1'b0;
            fire_dly_d = 1'b0;
            pending_d  = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    presc_d = '0;
                    if (clr_cnt_q == '0) begin
                        state_d = run ? ST_RUN : ST_IDLE;
                    end else begin
                        clr_cnt_d = clr_cnt_q - 1'b1;
                    end
                end
                ST_IDLE: begin
                    presc_d  = '0;
                    step_acc = step;
                    if (run) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d = ST_IDLE;
                        presc_d = '0;
                    end else if (presc_q >= period) begin
                        tick    = 1'b1;
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = CLR_RELOAD;
                    presc_d   = '0;
                end
            endcase

            // Depth-1 queue: a tick arriving while a count still waits is lost.
            if (tick && pending_q && !fire) begin
                overrun_d = 1'b1;
            end
            pending_d = tick | step_acc | (pending_q & ~fire);
        end

        rst_n_d = (state_d != ST_CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_cnt_q  <= CLR_RELOAD;
            presc_q    <= '0;
            pending_q  <= 1'b0;
            fire_dly_q <= 1'b0;
            value_q    <= '0;
            wrap_q     <= 1'b0;
            overrun_q  <= 1'b0;
            rst_n_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            presc_q    <= presc_d;
            pending_q  <= pending_d;
            fire_dly_q <= fire_dly_d;
            value_q    <= value_d;
            wrap_q     <= wrap_d;
            overrun_q  <= overrun_d;
            rst_n_q    <= rst_n_d;
        end
    end

    assign ctr_en    = pending_q;
    assign ctr_rst_n = rst_n_q;
    assign count_q   = value_q;
    assign wrap      = wrap_q;
    assign overrun   = overrun_q;
    assign state     = state_q;

endmodule

// File: tb/tb_count_tick_sched.sv
// Bench for count_tick_sched: directed scenarios plus random stimulus checked
// every cycle against a behavioural model of the scheduler and the counter.
module tb_count_tick_sched;

    localparam int PW = 23;
    localparam int CW = 4;
    localparam int CC = 2;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          run, step, clear, ctr_rdy;
    logic [PW-1:0] period;
    logic          ctr_en, ctr_rst_n, wrap, overrun;
    logic [CW-1:0] ctr_value = '0;
    logic [CW-1:0] count_q;
    logic [1:0]    state;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_on = 0;
    int en_cnt, wrap_cnt, ov_cnt, fire_cnt;

    // Model: mode 0=CLEAR 1=IDLE 2=RUN; m_ctr is what the counter should hold.
    int m_mode  = 0;
    int m_clr   = CC - 1;
    int m_presc = 0;
    int m_ctr   = 0;
    int m_count = 0;
    bit m_pend  = 0;
    bit m_over  = 0;
    bit m_fire_d = 0;
    bit m_wrap  = 0;

    count_tick_sched #(
        .PRESCALE_W   (PW),
        .COUNT_W      (CW),
        .CLEAR_CYCLES (CC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .step      (step),
        .clear     (clear),
        .period    (period),
        .ctr_en    (ctr_en),
        .ctr_rdy   (ctr_rdy),
        .ctr_rst_n (ctr_rst_n),
        .ctr_value (ctr_value),
        .count_q   (count_q),
        .wrap      (wrap),
        .overrun   (overrun),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Stand-in for the Bluespec counter: synchronous active-low reset.
    always @(posedge clk) begin
        if (!ctr_rst_n) ctr_value <= '0;
        else if (ctr_en && ctr_rdy) ctr_value <= ctr_value + 1'b1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit fire, tick, take;
        int n_ctr, n_count, n_mode;
        bit n_wrap;
        if (reset) begin
            m_mode = 0; m_clr = CC - 1; m_presc = 0; m_ctr = 0; m_count = 0;
            m_pend = 0; m_over = 0; m_fire_d = 0; m_wrap = 0;
        end else begin
            fire = m_pend && ctr_rdy;
            tick = 0;
            take = 0;
            n_ctr   = (m_mode == 0) ? 0 : (fire ? (m_ctr + 1) % (1 << CW) : m_ctr);
            n_count = m_fire_d ? m_ctr : m_count;
            n_wrap  = m_fire_d && (m_count == (1 << CW) - 1) && (m_ctr == 0);
            if (clear) begin
                m_mode = 0; m_clr = CC - 1; m_presc = 0; m_pend = 0; m_over = 0;
                m_fire_d = 0; m_count = 0; m_wrap = 0; m_ctr = n_ctr;
            end else begin
                n_mode = m_mode;
                case (m_mode)
                    0: if (m_clr == 0) n_mode = run ? 2 : 1; else m_clr--;
                    1: begin
                        take = step;
                        if (run) begin n_mode = 2; m_presc = 0; end
                    end
                    default: begin
                        if (!run) begin n_mode = 1; m_presc = 0; end
                        else if (m_presc >= int'(period)) begin tick = 1; m_presc = 0; end
                        else m_presc++;
                    end
                endcase
                if (tick && m_pend && !fire) m_over = 1;
                m_pend   = tick || take || (m_pend && !fire);
                m_fire_d = fire;
                m_count  = n_count;
                m_wrap   = n_wrap;
                m_ctr    = n_ctr;
                m_mode   = n_mode;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_val("ctr_en",    ctr_en,    m_pend);
            check_val("ctr_rst_n", ctr_rst_n, m_mode != 0);
            check_val("state",     state,     m_mode);
            check_val("count_q",   count_q,   m_count);
            check_val("wrap",      wrap,      m_wrap);
            check_val("overrun",   overrun,   m_over);
        end
    end

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (state != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_state", state, s);
    endtask

    task automatic pulse_clear();
        clear = 1;
        @(negedge clk);
        clear = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        run = 0; step = 0; clear = 0; period = '0; ctr_rdy = 1;
        #1 reset = 1;
        repeat (3) @(negedge clk);
        check_val("rst_state",   state,     0);
        check_val("rst_rst_n",   ctr_rst_n, 0);
        check_val("rst_ctr_en",  ctr_en,    0);
        check_val("rst_count_q", count_q,   0);
        check_val("rst_wrap",    wrap,      0);
        check_val("rst_overrun", overrun,   0);
        chk_on = 1;
        reset  = 0;

        // Paused: four step pulses, one count each.
        wait_state(1, 10);
        en_cnt = 0;
        for (int p = 0; p < 4; p++) begin
            step = 1;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                step = 0;
                if (ctr_en) en_cnt++;
            end
        end
        check_val("t1_en_cycles", en_cnt,  4);
        check_val("t1_count_q",   count_q, 4);
        check_val("t1_overrun",   overrun, 0);

        // Free run, period 3: one count every 4th cycle.
        run = 1; period = 3;
        pulse_clear();
        wait_state(2, 10);
        en_cnt = 0; wrap_cnt = 0;
        for (int i = 0; i < 41; i++) begin
            if (ctr_en) en_cnt++;
            if (wrap) wrap_cnt++;
            if (i < 40) @(negedge clk);
        end
        run = 0;
        repeat (5) @(negedge clk);
        check_val("t2_en_cycles", en_cnt,   10);
        check_val("t2_wraps",     wrap_cnt, 0);
        check_val("t2_count_q",   count_q,  10);

        // Period 0: enable held high, count wraps once in 20 cycles.
        run = 1; period = 0;
        pulse_clear();
        wait_state(2, 10);
        en_cnt = 0; wrap_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (ctr_en) en_cnt++;
            if (wrap) wrap_cnt++;
            if (i < 19) @(negedge clk);
        end
        check_val("t3_en_cycles", en_cnt,   19);
        check_val("t3_wraps",     wrap_cnt, 1);

        // Stalled counter: second tick overruns, one fire once ready returns.
        period = 2; ctr_rdy = 0;
        pulse_clear();
        wait_state(2, 10);
        en_cnt = 0; ov_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            if (ctr_en) en_cnt++;
            if (overrun) ov_cnt++;
            if (i < 10) @(negedge clk);
        end
        check_val("t4_en_cycles", en_cnt, 7);
        check_val("t4_ov_cycles", ov_cnt, 4);
        ctr_rdy = 1; run = 0; fire_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (ctr_en && ctr_rdy) fire_cnt++;
            @(negedge clk);
        end
        check_val("t4_fires",   fire_cnt, 1);
        check_val("t4_sticky",  overrun,  1);
        check_val("t4_en_idle", ctr_en,   0);

        // Clear while a count is pending.
        run = 1; period = 0; ctr_rdy = 0;
        repeat (6) @(negedge clk);
        check_val("t5_pre_en", ctr_en,  1);
        check_val("t5_pre_ov", overrun, 1);
        clear = 1; ctr_rdy = 1;
        @(negedge clk);
        clear = 0;
        check_val("t5_state0", state,     0);
        check_val("t5_rstn0",  ctr_rst_n, 0);
        check_val("t5_en0",    ctr_en,    0);
        check_val("t5_count",  count_q,   0);
        check_val("t5_ov",     overrun,   0);
        @(negedge clk);
        check_val("t5_state1", state,     0);
        check_val("t5_rstn1",  ctr_rst_n, 0);
        @(negedge clk);
        check_val("t5_state2", state,     2);
        check_val("t5_rstn2",  ctr_rst_n, 1);

        // Asynchronous reset off the clock edge while enable is high.
        repeat (4) @(negedge clk);
        check_val("t6_pre_en", ctr_en, 1);
        @(posedge clk);
        #2 reset = 1;
        #1;
        check_val("t6_en",    ctr_en,    0);
        check_val("t6_rst_n", ctr_rst_n, 0);
        check_val("t6_state", state,     0);
        @(negedge clk);
        reset = 0;

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 29) == 0) period = PW'($urandom_range(0, 6));
            step    = ($urandom_range(0, 7) == 0);
            clear   = ($urandom_range(0, 79) == 0);
            ctr_rdy = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        step = 0; clear = 0; run = 0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
